// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-SRAM responder.
package dmem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  // Big-endian lanes: byte offset 0 drives wen[3] / bits [31:24].
  localparam logic [3:0] WEN_READ    = 4'b0000;
  localparam logic [3:0] WEN_WORD    = 4'b1111;
  localparam logic [3:0] WEN_HALF_HI = 4'b1100;
  localparam logic [3:0] WEN_HALF_LO = 4'b0011;
  localparam logic [3:0] WEN_BYTE0   = 4'b1000;
  localparam logic [3:0] WEN_BYTE1   = 4'b0100;
  localparam logic [3:0] WEN_BYTE2   = 4'b0010;
  localparam logic [3:0] WEN_BYTE3   = 4'b0001;

  localparam int unsigned LATENCY_MAX = 15;

  function automatic logic wen_legal(input logic [3:0] wen);
    case (wen)
      WEN_READ, WEN_WORD, WEN_HALF_HI, WEN_HALF_LO,
      WEN_BYTE0, WEN_BYTE1, WEN_BYTE2, WEN_BYTE3: return 1'b1;
      default:                                    return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/dmem_bram.sv
// DEPTH x 32 storage with per-byte write enables and a registered read port.
// The array itself is never reset; only the read register is.
module dmem_bram
  import dmem_pkg::*;
#(
  parameter int unsigned DEPTH  = 1024,
  parameter int unsigned ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [3:0]        be,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [31:0]       wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [31:0]       rdata
);

  logic [31:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (be[i]) mem[waddr][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)  rdata <= '0;
    else if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/dmem_responder.sv
// Data-SRAM responder: one outstanding request, LATENCY wait states, then a
// one-cycle data_ok. Optional macro DMEM_WEN_CHECK_EN flags illegal wen patterns.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int unsigned DEPTH   = 1024,
  parameter int unsigned ADDR_W  = 10,
  parameter int unsigned LATENCY = 1
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        data_sram_en,
  input  logic [3:0]  data_sram_wen,
  input  logic [31:0] data_sram_addr,
  input  logic [31:0] data_sram_wdata,
  output logic        data_sram_addr_ok,
  output logic        data_sram_data_ok,
  output logic [31:0] data_sram_rdata,
  output logic        data_sram_err
);

  localparam logic [3:0] CNT_LOAD = (LATENCY == 0) ? 4'd0 : 4'(LATENCY - 1);

  state_t            state, state_next;
  logic [3:0]        cnt, cnt_next;
  logic              accept;
  logic [3:0]        req_wen;
  logic [ADDR_W-1:0] req_idx;
  logic [31:0]       req_wdata;
  logic              req_bad;
  logic [ADDR_W-1:0] in_idx;
  logic [ADDR_W-1:0] rd_idx;
  logic              mem_we;
  logic              mem_re;
  logic              unused_addr_bits;

  assign in_idx           = data_sram_addr[ADDR_W+1:2];
  assign unused_addr_bits = ^{data_sram_addr[31:ADDR_W+2], data_sram_addr[1:0]};

  always_comb begin
    state_next        = state;
    cnt_next          = cnt;
    accept            = 1'b0;
    data_sram_addr_ok = 1'b0;
    data_sram_data_ok = 1'b0;
    unique case (state)
      IDLE: begin
        data_sram_addr_ok = data_sram_en;
        if (data_sram_en) begin
          accept = 1'b1;
          if (LATENCY == 0) begin
            state_next = RESP;
          end else begin
            state_next = WAIT;
            cnt_next   = CNT_LOAD;
          end
        end
      end
      WAIT: begin
        if (cnt == '0) state_next = RESP;
        else           cnt_next   = cnt - 4'd1;
      end
      RESP: begin
        data_sram_data_ok = 1'b1;
        state_next        = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state     <= IDLE;
      cnt       <= '0;
      req_wen   <= '0;
      req_idx   <= '0;
      req_wdata <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
      if (accept) begin
        req_wen   <= data_sram_wen;
        req_idx   <= in_idx;
        req_wdata <= data_sram_wdata;
      end
    end
  end

`ifdef DMEM_WEN_CHECK_EN
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)     req_bad <= 1'b0;
    else if (accept) req_bad <= !wen_legal(data_sram_wen);
  end
`else
  assign req_bad = 1'b0;
`endif

  assign data_sram_err = (state == RESP) && req_bad;

  // The read is launched on the edge entering RESP; with LATENCY=0 that edge is
  // also the acceptance edge, so the index/wen come straight from the inputs.
  assign rd_idx = (state == IDLE) ? in_idx : req_idx;
  assign mem_re = (state_next == RESP) &&
                  ((state == IDLE) ? (data_sram_wen == WEN_READ) : (req_wen == WEN_READ));
  assign mem_we = (state == RESP) && (req_wen != WEN_READ) && !req_bad;

  dmem_bram #(
    .DEPTH (DEPTH),
    .ADDR_W(ADDR_W)
  ) u_bram (
    .clk  (clk),
    .rst_n(resetn),
    .we   (mem_we),
    .be   (req_wen),
    .waddr(req_idx),
    .wdata(req_wdata),
    .re   (mem_re),
    .raddr(rd_idx),
    .rdata(data_sram_rdata)
  );

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: vector table on a LATENCY=1 instance plus
// reset and back-to-back sequences on LATENCY=0 / LATENCY=3 instances.
module tb_dmem_responder;

`ifdef DMEM_WEN_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        resetn;
  logic        en;
  logic [3:0]  wen;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        addr_ok, data_ok, err;
  logic [31:0] rdata;

  logic [1:0]  en_x;
  logic        aok_l0, dok_l0, err_l0, aok_l3, dok_l3, err_l3;
  logic [31:0] rd_l0, rd_l3;

  always #5 clk = ~clk;

  dmem_responder #(.DEPTH(1024), .ADDR_W(10), .LATENCY(1)) dut (
    .clk(clk), .resetn(resetn), .data_sram_en(en), .data_sram_wen(wen),
    .data_sram_addr(addr), .data_sram_wdata(wdata), .data_sram_addr_ok(addr_ok),
    .data_sram_data_ok(data_ok), .data_sram_rdata(rdata), .data_sram_err(err));

  dmem_responder #(.DEPTH(1024), .ADDR_W(10), .LATENCY(0)) dut_l0 (
    .clk(clk), .resetn(resetn), .data_sram_en(en_x[0]), .data_sram_wen(4'b0000),
    .data_sram_addr(32'h0000_0010), .data_sram_wdata(32'h0), .data_sram_addr_ok(aok_l0),
    .data_sram_data_ok(dok_l0), .data_sram_rdata(rd_l0), .data_sram_err(err_l0));

  dmem_responder #(.DEPTH(1024), .ADDR_W(10), .LATENCY(3)) dut_l3 (
    .clk(clk), .resetn(resetn), .data_sram_en(en_x[1]), .data_sram_wen(4'b0000),
    .data_sram_addr(32'h0000_0010), .data_sram_wdata(32'h0), .data_sram_addr_ok(aok_l3),
    .data_sram_data_ok(dok_l3), .data_sram_rdata(rd_l3), .data_sram_err(err_l3));

  int n_cmp = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One request on the LATENCY=1 instance; lat counts cycles from addr_ok to data_ok.
  task automatic run_req(input logic [3:0] w, input logic [31:0] a, input logic [31:0] d,
                         output logic aok, output int lat, output logic [31:0] rd,
                         output logic er, output logic pulse_ok);
    @(negedge clk);
    en = 1'b1; wen = w; addr = a; wdata = d;
    #1 aok = addr_ok;
    @(negedge clk);
    en = 1'b0;
    lat = 1;
    while (!data_ok && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    rd = rdata;
    er = err;
    @(negedge clk);
    pulse_ok = !data_ok;
  endtask

  typedef struct {
    logic [3:0]  wen;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        err;
  } vec_t;

  vec_t vt[16];

  initial begin
    logic        aok, er, pok;
    int          lat;
    logic [31:0] rd;
    logic [31:0] final_word;

    final_word = CHK ? 32'hAA77_55EE : 32'hFF77_FFEE;
    vt[0]  = '{4'b1111, 32'h0000_0010, 32'hDEAD_BEEF, 32'h0000_0000, 1'b0};
    vt[1]  = '{4'b0000, 32'h0000_0010, 32'h0,         32'hDEAD_BEEF, 1'b0};
    vt[2]  = '{4'b1111, 32'h0000_0010, 32'h1122_3344, 32'hDEAD_BEEF, 1'b0};
    vt[3]  = '{4'b1000, 32'h0000_0010, 32'hAAAA_AAAA, 32'hDEAD_BEEF, 1'b0};
    vt[4]  = '{4'b0000, 32'h0000_0010, 32'h0,         32'hAA22_3344, 1'b0};
    vt[5]  = '{4'b0011, 32'h0000_0010, 32'h5555_5555, 32'hAA22_3344, 1'b0};
    vt[6]  = '{4'b0000, 32'h0000_0010, 32'h0,         32'hAA22_5555, 1'b0};
    vt[7]  = '{4'b0000, 32'h0000_1010, 32'h0,         32'hAA22_5555, 1'b0};
    vt[8]  = '{4'b1111, 32'h0000_1014, 32'hCAFE_F00D, 32'hAA22_5555, 1'b0};
    vt[9]  = '{4'b0000, 32'h0000_0014, 32'h0,         32'hCAFE_F00D, 1'b0};
    vt[10] = '{4'b1010, 32'h0000_0010, 32'hFFFF_FFFF, 32'hCAFE_F00D, CHK};
    vt[11] = '{4'b0000, 32'h0000_0010, 32'h0,
               (CHK ? 32'hAA22_5555 : 32'hFF22_FF55), 1'b0};
    vt[12] = '{4'b0100, 32'h0000_0013, 32'h0077_0000, vt[11].rdata, 1'b0};
    vt[13] = '{4'b0001, 32'h0000_0012, 32'h0000_00EE, vt[11].rdata, 1'b0};
    vt[14] = '{4'b0000, 32'h0000_0010, 32'h0,         final_word,   1'b0};
    vt[15] = '{4'b1111, 32'h0000_0020, 32'h0000_0000, final_word,   1'b0};

    resetn = 1'b0; en = 1'b0; wen = '0; addr = '0; wdata = '0; en_x = '0;
    repeat (3) @(negedge clk);
    check("rst_addr_ok", addr_ok, 1'b0);
    check("rst_data_ok", data_ok, 1'b0);
    check("rst_rdata",   rdata,   32'h0);
    check("rst_err",     err,     1'b0);
    resetn = 1'b1;
    @(negedge clk);
    check("idle_data_ok", data_ok, 1'b0);
    check("idle_rdata",   rdata,   32'h0);

    for (int i = 0; i < 16; i++) begin
      run_req(vt[i].wen, vt[i].addr, vt[i].wdata, aok, lat, rd, er, pok);
      check($sformatf("v%0d_addr_ok", i), aok, 1'b1);
      check($sformatf("v%0d_latency", i), lat, 2);
      check($sformatf("v%0d_rdata", i),   rd,  vt[i].rdata);
      check($sformatf("v%0d_err", i),     er,  vt[i].err);
      check($sformatf("v%0d_one_cycle", i), pok, 1'b1);
    end

    // Reset while a write to 0x20 sits in WAIT: the write must never commit.
    @(negedge clk);
    en = 1'b1; wen = 4'b1111; addr = 32'h0000_0020; wdata = 32'h1234_5678;
    @(negedge clk);
    en = 1'b0;
    check("rstA_wait_data_ok", data_ok, 1'b0);
    resetn = 1'b0;
    #1;
    check("rstA_data_ok", data_ok, 1'b0);
    check("rstA_rdata",   rdata,   32'h0);
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    run_req(4'b0000, 32'h0000_0020, 32'h0, aok, lat, rd, er, pok);
    check("rstA_read_latency", lat, 2);
    check("rstA_read_rdata",   rd,  32'h0);

    // Reset during RESP: data_ok must fall without waiting for a clock edge.
    @(negedge clk);
    en = 1'b1; wen = 4'b0000; addr = 32'h0000_0010;
    @(negedge clk);
    en = 1'b0;
    lat = 1;
    while (!data_ok && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    check("rstB_resp_data_ok", data_ok, 1'b1);
    check("rstB_resp_rdata",   rdata,   final_word);
    #1 resetn = 1'b0;
    #1;
    check("rstB_data_ok_async", data_ok, 1'b0);
    check("rstB_rdata",         rdata,   32'h0);
    @(negedge clk);
    resetn = 1'b1;
    run_req(4'b0000, 32'h0000_1010, 32'h0, aok, lat, rd, er, pok);
    check("post_rst_rdata", rd, final_word);

    // en held high on LATENCY=0 and LATENCY=3 instances for four reads each.
    begin : back_to_back
      int  last[2], nd[2], na[2], ovl[2], first_acc[2];
      int  exp_sp[2], exp_first[2];
      bit  stop[2];
      logic [1:0] a, d;
      exp_sp    = '{2, 5};
      exp_first = '{1, 4};
      for (int k = 0; k < 2; k++) begin
        last[k] = 0; nd[k] = 0; na[k] = 0; ovl[k] = 0; first_acc[k] = 0; stop[k] = 1'b0;
      end
      @(negedge clk);
      en_x = 2'b11;
      for (int cyc = 0; cyc < 60; cyc++) begin
        #1;
        a = {aok_l3, aok_l0};
        d = {dok_l3, dok_l0};
        for (int k = 0; k < 2; k++) begin
          if (a[k] && d[k]) ovl[k]++;
          if (a[k]) begin
            if (na[k] == 0) first_acc[k] = cyc;
            na[k]++;
            if (na[k] == 4) stop[k] = 1'b1;
          end
          if (d[k]) begin
            if (nd[k] == 0)
              check($sformatf("b2b%0d_first_latency", k), cyc - first_acc[k], exp_first[k]);
            else
              check($sformatf("b2b%0d_spacing%0d", k, nd[k]), cyc - last[k], exp_sp[k]);
            last[k] = cyc;
            nd[k]++;
          end
        end
        @(negedge clk);
        for (int k = 0; k < 2; k++) if (stop[k]) en_x[k] = 1'b0;
      end
      for (int k = 0; k < 2; k++) begin
        check($sformatf("b2b%0d_accepts", k),   na[k],  4);
        check($sformatf("b2b%0d_responses", k), nd[k],  4);
        check($sformatf("b2b%0d_overlap", k),   ovl[k], 0);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
